tiling: RTL and testbench

- Tiling DMA controller between off-chip DRAM and the accelerator global buffer (GLB).
- Each `start` pulse makes it:
  - write back the previous tile's output partial sums (opsum) to DRAM, if any;
  - stage the next ifmap, filter and bias tile into GLB;
  - pulse `finish` so the DLA core can compute in GLB.
- After the last tile has been written back, it raises `done` together with `finish`.

---
 rtl/tiling.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_tiling.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiling.sv
// -----------------------------------------------------------------------------
// tiling: DMA controller moving tiles between off-chip DRAM and the accelerator
// global buffer (GLB).
//
// Each start request:
//   1. writes the previous tile's output partial sums back to DRAM, provided
//      that tile has finished its last input-channel tile;
//   2. stages the next ifmap, filter and (on the first ic tile) bias tile into
//      GLB, initialising the opsum tile with the bias;
//   3. pulses finish so the DLA core can compute in GLB.
// After the last tile has been written back, finish is pulsed together with
// done, which is then held until rst.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start / finish       step request / one-cycle step-complete pulse
//   done                 all tiles written back (held)
//   controller_glb_addr  GLB address of the opsum tile
//   mapping_param        [14:12]=e [11:9]=p [8:6]=q [5:3]=r [2:0]=t
//   shape_param1         [25:24]=U [23:22]=R [21:20]=S [19:10]=C [9:0]=M
//   shape_param2         [15:8]=H [7:0]=W
//   dram_*_base_addr     DRAM byte bases of ifmap/filter/bias/opsum
//   glb_*_base_addr      GLB byte bases of ifmap/filter/bias/opsum
//   dram_we/addr/w_data  DRAM port; dram_r_data valid one cycle after dram_addr
//   glb_re/r_addr/r_data GLB read port (byte mask, 1-cycle latency)
//   glb_we/w_addr/w_data GLB write port (byte mask)
// -----------------------------------------------------------------------------
module tiling #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    finish,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   controller_glb_addr,
    input  logic [31:0]             mapping_param,
    input  logic [31:0]             shape_param1,
    input  logic [31:0]             shape_param2,
    input  logic [ADDR_WIDTH-1:0]   dram_ifmap_base_addr,
    input  logic [ADDR_WIDTH-1:0]   dram_filter_base_addr,
    input  logic [ADDR_WIDTH-1:0]   dram_bias_base_addr,
    input  logic [ADDR_WIDTH-1:0]   dram_opsum_base_addr,
    input  logic [ADDR_WIDTH-1:0]   glb_ifmap_base_addr,
    input  logic [ADDR_WIDTH-1:0]   glb_filter_base_addr,
    input  logic [ADDR_WIDTH-1:0]   glb_bias_base_addr,
    input  logic [ADDR_WIDTH-1:0]   glb_opsum_base_addr,
    output logic                    dram_we,
    output logic [ADDR_WIDTH-1:0]   dram_addr,
    output logic [4*DATA_WIDTH-1:0] dram_w_data,
    input  logic [4*DATA_WIDTH-1:0] dram_r_data,
    output logic [3:0]              glb_re,
    output logic [ADDR_WIDTH-1:0]   glb_r_addr,
    input  logic [4*DATA_WIDTH-1:0] glb_r_data,
    output logic [3:0]              glb_we,
    output logic [ADDR_WIDTH-1:0]   glb_w_addr,
    output logic [4*DATA_WIDTH-1:0] glb_w_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD_IF,
        ST_LOAD_FLT,
        ST_LOAD_BIAS,
        ST_INIT_PSUM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    // ---------------- configuration fields and tile geometry ----------------
    logic [31:0] m_e, m_p, m_q, m_r, m_t;
    logic [31:0] sh_u, sh_r, sh_s, sh_c, sh_m, sh_h, sh_w;
    logic [31:0] out_w, out_h, pt, qr, in_rows;
    logic [31:0] oc_tiles, row_tiles, ic_tiles;

    assign m_e  = 32'(mapping_param[14:12]);
    assign m_p  = 32'(mapping_param[11:9]);
    assign m_q  = 32'(mapping_param[8:6]);
    assign m_r  = 32'(mapping_param[5:3]);
    assign m_t  = 32'(mapping_param[2:0]);
    assign sh_u = 32'(shape_param1[25:24]);
    assign sh_r = 32'(shape_param1[23:22]);
    assign sh_s = 32'(shape_param1[21:20]);
    assign sh_c = 32'(shape_param1[19:10]);
    assign sh_m = 32'(shape_param1[9:0]);
    assign sh_h = 32'(shape_param2[15:8]);
    assign sh_w = 32'(shape_param2[7:0]);

    // Padding field is required to be zero and is not consumed.
    logic unused_cfg;
    assign unused_cfg = &{1'b0, mapping_param[31:15], shape_param1[31:26],
                          shape_param2[31:16]};

    assign out_w     = (sh_w - sh_s) / sh_u + 32'd1;
    assign out_h     = (sh_h - sh_r) / sh_u + 32'd1;
    assign pt        = m_p * m_t;
    assign qr        = m_q * m_r;
    assign in_rows   = sh_u * (m_e - 32'd1) + sh_r;
    assign oc_tiles  = sh_m / pt;
    assign row_tiles = out_h / m_e;
    assign ic_tiles  = sh_c / qr;

    // ---------------- tile position ----------------
    logic [31:0] oc_t, row_t, ic_t;
    logic [31:0] oc0, row0, ic0;
    logic [31:0] st_oc0, st_row0;   // origin of the tile awaiting write-back
    logic        pending;           // a finished tile still lives in GLB opsum
    logic        all_loaded;        // every tile has been computed
    logic        done_seen;

    assign oc0  = oc_t * pt;
    assign row0 = row_t * m_e;
    assign ic0  = ic_t * qr;

    // ---------------- transfer loop counters ----------------
    // Every transfer is two cycles: phase 0 issues the read, phase 1 writes
    // the returned data. c0 is the innermost index.
    logic [31:0] c0, c1, c2;
    logic [31:0] lim0, lim1, lim2;
    logic        phase;
    logic        wrap0, wrap1, wrap2, last, looping;

    always_comb begin
        lim0 = 32'd1;
        lim1 = 32'd1;
        lim2 = 32'd1;
        case (state)
            ST_STORE, ST_INIT_PSUM: begin
                lim2 = m_e;  lim1 = out_w; lim0 = pt;
            end
            ST_LOAD_IF: begin
                lim2 = in_rows; lim1 = sh_w; lim0 = qr;
            end
            ST_LOAD_FLT: begin
                lim2 = sh_r * sh_s; lim1 = qr; lim0 = pt;
            end
            ST_LOAD_BIAS: lim0 = pt;
            default: ;
        endcase
    end

    assign wrap0   = (c0 == lim0 - 32'd1);
    assign wrap1   = (c1 == lim1 - 32'd1);
    assign wrap2   = (c2 == lim2 - 32'd1);
    assign last    = phase && wrap0 && wrap1 && wrap2;
    assign looping = (state == ST_STORE) || (state == ST_LOAD_IF) ||
                     (state == ST_LOAD_FLT) || (state == ST_LOAD_BIAS) ||
                     (state == ST_INIT_PSUM);

    // ---------------- address offsets ----------------
    logic [31:0] opsum_off, st_dram_off, if_dram_off, if_glb_off;
    logic [31:0] flt_dram_off, flt_glb_off;
    logic [4*DATA_WIDTH-1:0] byte_data;

    assign opsum_off    = ((c2 * out_w + c1) * pt + c0) << 2;
    assign st_dram_off  = (((st_row0 + c2) * out_w + c1) * sh_m + st_oc0 + c0) << 2;
    assign if_dram_off  = ((sh_u * row0 + c2) * sh_w + c1) * sh_c + ic0 + c0;
    assign if_glb_off   = (c2 * sh_w + c1) * qr + c0;
    assign flt_dram_off = (c2 * sh_c + ic0 + c1) * sh_m + oc0 + c0;
    assign flt_glb_off  = (c2 * qr + c1) * pt + c0;
    assign byte_data    = {{(3*DATA_WIDTH){1'b0}}, dram_r_data[DATA_WIDTH-1:0]};

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_nxt   = state;
        finish      = 1'b0;
        done        = 1'b0;
        dram_we     = 1'b0;
        dram_addr   = '0;
        dram_w_data = '0;
        glb_re      = '0;
        glb_r_addr  = '0;
        glb_we      = '0;
        glb_w_addr  = '0;
        glb_w_data  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (pending)         state_nxt = ST_STORE;
                    else if (all_loaded) state_nxt = ST_DONE;
                    else                 state_nxt = ST_LOAD_IF;
                end
            end
            ST_STORE: begin
                if (!phase) begin
                    glb_re     = 4'b1111;
                    glb_r_addr = glb_opsum_base_addr + ADDR_WIDTH'(opsum_off);
                end else begin
                    dram_we     = 1'b1;
                    dram_addr   = dram_opsum_base_addr + ADDR_WIDTH'(st_dram_off);
                    dram_w_data = glb_r_data;
                end
                if (last) state_nxt = all_loaded ? ST_DONE : ST_LOAD_IF;
            end
            ST_LOAD_IF: begin
                dram_addr = dram_ifmap_base_addr + ADDR_WIDTH'(if_dram_off);
                if (phase) begin
                    glb_we     = 4'b0001;
                    glb_w_addr = glb_ifmap_base_addr + ADDR_WIDTH'(if_glb_off);
                    glb_w_data = byte_data;
                end
                if (last) state_nxt = ST_LOAD_FLT;
            end
            ST_LOAD_FLT: begin
                dram_addr = dram_filter_base_addr + ADDR_WIDTH'(flt_dram_off);
                if (phase) begin
                    glb_we     = 4'b0001;
                    glb_w_addr = glb_filter_base_addr + ADDR_WIDTH'(flt_glb_off);
                    glb_w_data = byte_data;
                end
                // Later ic tiles keep accumulating into the resident opsum.
                if (last) state_nxt = (ic_t == 32'd0) ? ST_LOAD_BIAS : ST_WAIT;
            end
            ST_LOAD_BIAS: begin
                dram_addr = dram_bias_base_addr + ADDR_WIDTH'((oc0 + c0) << 2);
                if (phase) begin
                    glb_we     = 4'b1111;
                    glb_w_addr = glb_bias_base_addr + ADDR_WIDTH'(c0 << 2);
                    glb_w_data = dram_r_data;
                end
                if (last) state_nxt = ST_INIT_PSUM;
            end
            ST_INIT_PSUM: begin
                // Bias comes back from GLB rather than DRAM, keeping DRAM idle.
                if (!phase) begin
                    glb_re     = 4'b1111;
                    glb_r_addr = glb_bias_base_addr + ADDR_WIDTH'(c0 << 2);
                end else begin
                    glb_we     = 4'b1111;
                    glb_w_addr = glb_opsum_base_addr + ADDR_WIDTH'(opsum_off);
                    glb_w_data = glb_r_data;
                end
                if (last) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                done   = 1'b1;
                finish = !done_seen;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            controller_glb_addr <= '0;
            oc_t                <= '0;
            row_t               <= '0;
            ic_t                <= '0;
            st_oc0              <= '0;
            st_row0             <= '0;
            pending             <= 1'b0;
            all_loaded          <= 1'b0;
            done_seen           <= 1'b0;
            c0                  <= '0;
            c1                  <= '0;
            c2                  <= '0;
            phase               <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != ST_IDLE) controller_glb_addr <= glb_opsum_base_addr;

            // Counters wrap to zero on the final transfer, so each loop
            // state starts from a clean origin.
            if (looping) begin
                phase <= ~phase;
                if (phase) begin
                    if (!wrap0) c0 <= c0 + 32'd1;
                    else begin
                        c0 <= '0;
                        if (!wrap1) c1 <= c1 + 32'd1;
                        else begin
                            c1 <= '0;
                            if (!wrap2) c2 <= c2 + 32'd1;
                            else        c2 <= '0;
                        end
                    end
                end
            end

            if (state == ST_STORE && last) pending <= 1'b0;

            // Advance ic -> row -> oc once the core has been released.
            if (state == ST_WAIT) begin
                if (ic_t == ic_tiles - 32'd1) begin
                    pending <= 1'b1;
                    st_oc0  <= oc0;
                    st_row0 <= row0;
                    ic_t    <= '0;
                    if (row_t == row_tiles - 32'd1) begin
                        row_t <= '0;
                        if (oc_t == oc_tiles - 32'd1) all_loaded <= 1'b1;
                        else                          oc_t <= oc_t + 32'd1;
                    end else begin
                        row_t <= row_t + 32'd1;
                    end
                end else begin
                    ic_t <= ic_t + 32'd1;
                end
            end

            if (state == ST_DONE) done_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tiling.sv
// -----------------------------------------------------------------------------
// tb_tiling: self-checking bench for the tiling DMA controller. Byte-addressed
// DRAM and GLB models surround the DUT; a reference convolution runs on GLB
// after every compute finish, and the final DRAM opsum is compared against a
// golden convolution computed straight from the DRAM inputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tiling;

    localparam int DSZ    = 16384;
    localparam int GSZ    = 2048;
    localparam int D_IF   = 32'h0000;
    localparam int D_FLT  = 32'h1000;
    localparam int D_BIAS = 32'h2000;
    localparam int D_OPS  = 32'h3000;
    localparam int G_IF   = 32'h000;
    localparam int G_FLT  = 32'h200;
    localparam int G_BIAS = 32'h300;
    localparam int G_OPS  = 32'h400;

    logic        clk = 1'b0;
    logic        rst, start, finish, done;
    logic [31:0] controller_glb_addr;
    logic [31:0] mapping_param, shape_param1, shape_param2;
    logic [31:0] dram_ifmap_base_addr, dram_filter_base_addr;
    logic [31:0] dram_bias_base_addr, dram_opsum_base_addr;
    logic [31:0] glb_ifmap_base_addr, glb_filter_base_addr;
    logic [31:0] glb_bias_base_addr, glb_opsum_base_addr;
    logic        dram_we;
    logic [31:0] dram_addr, dram_w_data, dram_r_data;
    logic [3:0]  glb_re, glb_we;
    logic [31:0] glb_r_addr, glb_r_data, glb_w_addr, glb_w_data;

    always #5 clk = ~clk;

    tiling #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .done(done),
        .controller_glb_addr(controller_glb_addr),
        .mapping_param(mapping_param), .shape_param1(shape_param1),
        .shape_param2(shape_param2),
        .dram_ifmap_base_addr(dram_ifmap_base_addr),
        .dram_filter_base_addr(dram_filter_base_addr),
        .dram_bias_base_addr(dram_bias_base_addr),
        .dram_opsum_base_addr(dram_opsum_base_addr),
        .glb_ifmap_base_addr(glb_ifmap_base_addr),
        .glb_filter_base_addr(glb_filter_base_addr),
        .glb_bias_base_addr(glb_bias_base_addr),
        .glb_opsum_base_addr(glb_opsum_base_addr),
        .dram_we(dram_we), .dram_addr(dram_addr), .dram_w_data(dram_w_data),
        .dram_r_data(dram_r_data),
        .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
        .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
    );

    // ---------------- memory models ----------------
    logic [7:0] dram [0:DSZ-1];
    logic [7:0] glb  [0:GSZ-1];

    function automatic logic [31:0] rd_dram(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) if (a + k < DSZ) v[8*k +: 8] = dram[a + k];
        return v;
    endfunction

    function automatic logic [31:0] rd_glb(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) if (a + k < GSZ) v[8*k +: 8] = glb[a + k];
        return v;
    endfunction

    always @(posedge clk) begin
        if (dram_we) begin
            for (int k = 0; k < 4; k++)
                if (dram_addr + k < DSZ) dram[dram_addr + k] = dram_w_data[8*k +: 8];
        end else begin
            dram_r_data <= rd_dram(dram_addr);
        end
        for (int k = 0; k < 4; k++)
            if (glb_we[k] && glb_w_addr + k < GSZ) glb[glb_w_addr + k] = glb_w_data[8*k +: 8];
        if (glb_re != 4'b0000) glb_r_data <= rd_glb(glb_r_addr);
    end

    // ---------------- event monitor ----------------
    int n_finish = 0;
    int n_store  = 0;
    int bus_err  = 0;

    function automatic bit legal_mask(input logic [3:0] m);
        return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0011) ||
               (m == 4'b0111) || (m == 4'b1111);
    endfunction

    always @(negedge clk) begin
        if (finish === 1'b1) n_finish++;
        if (dram_we === 1'b1) n_store++;
        if (glb_re != 4'b0000 && glb_we != 4'b0000) bus_err++;
        if (!legal_mask(glb_re) || !legal_mask(glb_we)) bus_err++;
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_finish(input string name);
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (finish === 1'b1) break;
        end
        if (i == 20000) begin
            tests++;
            fails++;
            $display("FAIL %s: no finish within 20000 cycles", name);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "timeout");
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // ---------------- configuration ----------------
    int cW, cH, cC, cM, cR, cS, cU, ce, cq, cr, cp, ct;

    task automatic set_cfg(input int w, input int h, input int c, input int m,
                           input int r, input int s, input int u, input int e,
                           input int q, input int rr, input int p, input int t);
        cW = w; cH = h; cC = c; cM = m; cR = r; cS = s; cU = u;
        ce = e; cq = q; cr = rr; cp = p; ct = t;
        mapping_param = 32'((e << 12) | (p << 9) | (q << 6) | (rr << 3) | t);
        shape_param1  = 32'((u << 24) | (r << 22) | (s << 20) | (c << 10) | m);
        shape_param2  = 32'((h << 8) | w);
    endtask

    task automatic init_mem();
        logic [31:0] b;
        for (int i = 0; i < DSZ; i++) dram[i] = 8'h00;
        for (int o = 0; o < 4096; o++) begin
            dram[D_IF + o]  = 8'((o * 7 + 3) & 255);
            dram[D_FLT + o] = 8'((o * 5 + 1) & 255);
        end
        for (int m = 0; m < 32; m++) begin
            b = 32'(100 * m - 300);
            for (int k = 0; k < 4; k++) dram[D_BIAS + 4*m + k] = b[8*k +: 8];
        end
        for (int i = 0; i < GSZ; i++) glb[i] = 8'hA5;
    endtask

    // Reference DLA core: accumulates one tile into the GLB opsum.
    task automatic dla_compute();
        int f, pt, qr, acc, a, iv, fv;
        f  = (cW - cS) / cU + 1;
        pt = cp * ct;
        qr = cq * cr;
        for (int h = 0; h < ce; h++)
            for (int w = 0; w < f; w++)
                for (int oc = 0; oc < pt; oc++) begin
                    a   = G_OPS + ((h * f + w) * pt + oc) * 4;
                    acc = int'(rd_glb(a));
                    for (int ic = 0; ic < qr; ic++)
                        for (int rr = 0; rr < cR; rr++)
                            for (int ss = 0; ss < cS; ss++) begin
                                iv  = int'(glb[G_IF + ((h*cU + rr)*cW + w*cU + ss)*qr + ic]);
                                fv  = int'($signed(glb[G_FLT + ((rr*cS + ss)*qr + ic)*pt + oc]));
                                acc = acc + iv * fv;
                            end
                    for (int k = 0; k < 4; k++) glb[a + k] = acc[8*k +: 8];
                end
    endtask

    // Golden convolution computed directly from the DRAM inputs.
    task automatic check_golden(input string name);
        int f, e_all, bad, exp, iv, fv;
        f     = (cW - cS) / cU + 1;
        e_all = (cH - cR) / cU + 1;
        bad   = 0;
        for (int h = 0; h < e_all; h++)
            for (int w = 0; w < f; w++)
                for (int m = 0; m < cM; m++) begin
                    exp = 100 * m - 300;
                    for (int c = 0; c < cC; c++)
                        for (int rr = 0; rr < cR; rr++)
                            for (int ss = 0; ss < cS; ss++) begin
                                iv  = int'(dram[D_IF + ((h*cU + rr)*cW + w*cU + ss)*cC + c]);
                                fv  = int'($signed(dram[D_FLT + ((rr*cS + ss)*cC + c)*cM + m]));
                                exp = exp + iv * fv;
                            end
                    if (rd_dram(D_OPS + ((h * f + w) * cM + m) * 4) !== exp) bad++;
                end
        check(name, 32'(bad), 32'd0);
    endtask

    // ---------------- probe table (config 1, after first finish) ----------------
    typedef struct {
        string       name;
        int          addr;
        int          nbytes;
        logic [31:0] exp;
    } probe_t;

    probe_t probes[12];

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_finish"},  32'(finish),  32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_dram_we"}, 32'(dram_we), 32'd0);
        check({tag, "_glb_we"},  32'(glb_we),  32'd0);
        check({tag, "_glb_re"},  32'(glb_re),  32'd0);
    endtask

    initial begin : main
        int f0, s0, k;
        logic [31:0] w0m, act;

        probes[0]  = '{"if_first",      G_IF + 0,    1, 32'd3};
        probes[1]  = '{"if_second",     G_IF + 1,    1, 32'd10};
        probes[2]  = '{"if_last",       G_IF + 179,  1, 32'd232};
        probes[3]  = '{"if_beyond",     G_IF + 180,  1, 32'h000000A5};
        probes[4]  = '{"flt_r1s2c0o3",  G_FLT + 63,  1, 32'd104};
        probes[5]  = '{"flt_r2s2c2o0",  G_FLT + 104, 1, 32'd17};
        probes[6]  = '{"flt_last",      G_FLT + 107, 1, 32'd32};
        probes[7]  = '{"bias_oc2",      G_BIAS + 8,  4, 32'hFFFFFF9C};
        probes[8]  = '{"bias_beyond",   G_BIAS + 16, 4, 32'hA5A5A5A5};
        probes[9]  = '{"psum_h0w0o0",   G_OPS + 0,   4, 32'hFFFFFED4};
        probes[10] = '{"psum_h3w7o1",   G_OPS + 500, 4, 32'hFFFFFF38};
        probes[11] = '{"psum_beyond",   G_OPS + 512, 4, 32'hA5A5A5A5};

        dram_ifmap_base_addr  = D_IF;
        dram_filter_base_addr = D_FLT;
        dram_bias_base_addr   = D_BIAS;
        dram_opsum_base_addr  = D_OPS;
        glb_ifmap_base_addr   = G_IF;
        glb_filter_base_addr  = G_FLT;
        glb_bias_base_addr    = G_BIAS;
        glb_opsum_base_addr   = G_OPS;

        // ---- reset ----
        rst = 1'b1;
        start = 1'b0;
        set_cfg(10, 10, 3, 8, 3, 3, 1, 4, 3, 1, 2, 2);
        init_mem();
        @(negedge clk);
        reset_outputs_zero("reset");
        check("reset_ctrl_addr", controller_glb_addr, 32'd0);
        rst = 1'b0;

        // ---- config 1: 2 oc tiles x 2 row tiles x 1 ic tile ----
        f0 = n_finish;
        s0 = n_store;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();                       // busy: must be ignored
        wait_finish("cfg1_tile0");
        check("cfg1_t0_done_low", 32'(done), 32'd0);
        check("cfg1_t0_no_store", 32'(n_store - s0), 32'd0);
        for (int i = 0; i < 12; i++) begin
            act = (probes[i].nbytes == 1) ? {24'd0, glb[probes[i].addr]} : rd_glb(probes[i].addr);
            check(probes[i].name, act, probes[i].exp);
        end
        dla_compute();
        for (k = 1; k < 4; k++) begin
            pulse_start();
            wait_finish("cfg1_tile");
            check("cfg1_done_low", 32'(done), 32'd0);
            if (k == 1) begin
                check("cfg1_t1_store_words", 32'(n_store - s0), 32'd128);
                check("cfg1_t1_if_row4", {24'd0, glb[G_IF]}, 32'd75);
            end
            dla_compute();
        end
        pulse_start();
        wait_finish("cfg1_done");
        check("cfg1_done_with_finish", 32'(done), 32'd1);
        check("cfg1_ctrl_glb_addr", controller_glb_addr, G_OPS);
        repeat (3) @(negedge clk);
        pulse_start();                       // after done: ignored
        repeat (50) @(negedge clk);
        check("cfg1_finish_count", 32'(n_finish - f0), 32'd5);
        check("cfg1_store_words", 32'(n_store - s0), 32'd512);
        check("cfg1_done_held", 32'(done), 32'd1);
        check_golden("cfg1_opsum_bad_words");

        // ---- abort in LOAD_IF of the second tile (after a STORE) ----
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rst_clears_done", 32'(done), 32'd0);
        init_mem();
        pulse_start();
        wait_finish("abort_tile0");
        pulse_start();
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (glb_we == 4'b0001) break;
        end
        check("abort_reached_load_if", 32'(k < 2000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        reset_outputs_zero("abort");
        check("abort_dram_addr", dram_addr, 32'd0);
        rst = 1'b0;

        // ---- config 2: C=6 with q*r=3 -> two ic tiles per output tile ----
        set_cfg(10, 10, 6, 8, 3, 3, 1, 4, 3, 1, 2, 2);
        init_mem();
        f0 = n_finish;
        s0 = n_store;
        pulse_start();
        wait_finish("cfg2_tile0_ic0");
        check("cfg2_ic0_psum_init", rd_glb(G_OPS), 32'hFFFFFED4);
        dla_compute();
        w0m = rd_glb(G_OPS);
        pulse_start();
        wait_finish("cfg2_tile0_ic1");
        check("cfg2_ic1_psum_kept", rd_glb(G_OPS), w0m);
        check("cfg2_ic1_no_store", 32'(n_store - s0), 32'd0);
        dla_compute();
        pulse_start();
        wait_finish("cfg2_tile1_ic0");
        check("cfg2_store_after_ic1", 32'(n_store - s0), 32'd128);
        dla_compute();
        for (k = 3; k < 8; k++) begin
            pulse_start();
            wait_finish("cfg2_tile");
            check("cfg2_done_low", 32'(done), 32'd0);
            dla_compute();
        end
        pulse_start();
        wait_finish("cfg2_done");
        check("cfg2_done_with_finish", 32'(done), 32'd1);
        repeat (5) @(negedge clk);
        check("cfg2_finish_count", 32'(n_finish - f0), 32'd9);
        check_golden("cfg2_opsum_bad_words");
        check("bus_exclusivity_violations", 32'(bus_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
